// File: rtl/psum_pkg.sv
// Shared definitions for the partial-sum collector: default widths, FSM states
// and the saturating adder used by the accumulator.
package psum_pkg;

    localparam int PSUM_W_DEF = 19;
    localparam int ACC_W_DEF  = 32;
    localparam int SAT_W      = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        ERR   = 2'd2
    } state_e;

    // Adds two sign-extended operands and clamps to the signed range of a w-bit word (w <= 64).
    function automatic logic signed [SAT_W-1:0] satAdd(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int                      w
    );
        logic signed [SAT_W:0] sum;
        logic signed [SAT_W:0] one;
        logic signed [SAT_W:0] maxV;
        logic signed [SAT_W:0] minV;
        sum  = {a[SAT_W-1], a} + {b[SAT_W-1], b};
        one  = {{SAT_W{1'b0}}, 1'b1};
        maxV = (one <<< (w - 1)) - one;
        minV = -(one <<< (w - 1));
        if (sum > maxV) begin
            return maxV[SAT_W-1:0];
        end else if (sum < minV) begin
            return minV[SAT_W-1:0];
        end
        return sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/psum_collector_sync_fifo.sv
// Output buffer for completed sums: DEPTH-entry power-of-two FIFO, head visible
// one cycle after the write that filled it, reads 0 while empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push;
    logic             pop;

    assign full_o    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign push      = wr_en_i && !full_o;
    assign pop       = rd_en_i && !empty_o;
    assign rd_data_o = empty_o ? '0 : mem_q[rdPtr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (push) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wrPtr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/psum_collector.sv
// Collects signed partial sums from a fusion-unit column tail, accumulates them
// over multiple passes with saturation, and queues completed sums for downstream.
module psum_collector
    import psum_pkg::*;
#(
    parameter int PSUM_W     = PSUM_W_DEF,
    parameter int ACC_W      = ACC_W_DEF,
    parameter int DEPTH      = 4,
    parameter int MAX_PASSES = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [PSUM_W-1:0] psum_in,
    input  logic                     psum_valid,
    input  logic                     psum_last,
    output logic                     psum_ready,
    output logic signed [ACC_W-1:0]  out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     pass_ovf
);

    localparam int                CNT_W    = $clog2(MAX_PASSES + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(MAX_PASSES - 1);

    state_e                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        passCnt_q, passCnt_d;
    logic signed [SAT_W-1:0] sumWide;
    logic signed [ACC_W-1:0] sumSat;
    logic                    accept;
    logic                    pushEn;
    logic                    popEn;
    logic                    fifoFull;
    logic                    fifoEmpty;

    assign accept  = psum_valid && psum_ready;
    assign sumWide = satAdd(SAT_W'(acc_q), SAT_W'(psum_in), ACC_W);
    assign sumSat  = sumWide[ACC_W-1:0];
    assign pushEn  = accept && psum_last;
    assign popEn   = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The accept that brings the pass count to MAX_PASSES is still taken, then the FSM locks in ERR.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    if (psum_last) begin
                        state_d = IDLE;
                    end else if (passCnt_q == LAST_CNT) begin
                        state_d = ERR;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        psum_ready = (state_q != ERR) && !fifoFull;
        pass_ovf   = (state_q == ERR);
    end

    always_comb begin
        acc_d     = acc_q;
        passCnt_d = passCnt_q;
        if (accept) begin
            if (psum_last) begin
                acc_d     = '0;
                passCnt_d = '0;
            end else begin
                acc_d     = sumSat;
                passCnt_d = passCnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            passCnt_q <= '0;
        end else begin
            acc_q     <= acc_d;
            passCnt_q <= passCnt_d;
        end
    end

    sync_fifo #(
        .WIDTH (ACC_W),
        .DEPTH (DEPTH)
    ) uFifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (pushEn),
        .wr_data_i (sumSat),
        .rd_en_i   (popEn),
        .rd_data_o (out_data),
        .full_o    (fifoFull),
        .empty_o   (fifoEmpty)
    );

    assign out_valid = !fifoEmpty;

endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector: a default-parameter instance for the main
// flow and a 32-bit-input instance to reach the saturation limits.
module tb_psum_collector;

    logic        clk;
    logic        rst_n;

    logic [18:0] psumIn;
    logic        psumValid;
    logic        psumLast;
    logic        psumReady;
    logic [31:0] outData;
    logic        outValid;
    logic        outReady;
    logic        passOvf;

    logic [31:0] satIn;
    logic        satValid;
    logic        satLast;
    logic        satReady;
    logic [31:0] satOutData;
    logic        satOutValid;
    logic        satOutReady;
    logic        satOvf;

    int total = 0;
    int bad   = 0;

    psum_collector dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .psum_in    (psumIn),
        .psum_valid (psumValid),
        .psum_last  (psumLast),
        .psum_ready (psumReady),
        .out_data   (outData),
        .out_valid  (outValid),
        .out_ready  (outReady),
        .pass_ovf   (passOvf)
    );

    psum_collector #(
        .PSUM_W (32),
        .ACC_W  (32)
    ) dutSat (
        .clk        (clk),
        .rst_n      (rst_n),
        .psum_in    (satIn),
        .psum_valid (satValid),
        .psum_last  (satLast),
        .psum_ready (satReady),
        .out_data   (satOutData),
        .out_valid  (satOutValid),
        .out_ready  (satOutReady),
        .pass_ovf   (satOvf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic v, input logic l, input logic [18:0] d, input logic r);
        psumValid = v;
        psumLast  = l;
        psumIn    = d;
        outReady  = r;
        @(posedge clk);
        #1;
    endtask

    task automatic applySat(input logic v, input logic l, input logic [31:0] d, input logic r);
        satValid    = v;
        satLast     = l;
        satIn       = d;
        satOutReady = r;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        psumIn = '0; psumValid = 1'b0; psumLast = 1'b0; outReady = 1'b0;
        satIn = '0; satValid = 1'b0; satLast = 1'b0; satOutReady = 1'b0;
        #12;
        checkOutput("rst_ready", psumReady, 1);
        checkOutput("rst_valid", outValid, 0);
        checkOutput("rst_data", outData, 0);
        checkOutput("rst_ovf", passOvf, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single pass -5: visible one cycle after the accepting edge.
        applyStimulus(1, 1, 19'h7FFFB, 0);
        checkOutput("single_valid", outValid, 1);
        checkOutput("single_data", outData, 32'hFFFFFFFB);
        applyStimulus(0, 0, 0, 1);
        checkOutput("single_popped", outValid, 0);

        // Three passes 100+200+300.
        applyStimulus(1, 0, 19'd100, 0);
        checkOutput("acc_p1_valid", outValid, 0);
        applyStimulus(1, 0, 19'd200, 0);
        checkOutput("acc_p2_valid", outValid, 0);
        applyStimulus(1, 1, 19'd300, 0);
        checkOutput("acc_valid", outValid, 1);
        checkOutput("acc_data", outData, 32'd600);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(1, 1, 19'h7FFFB, 0);
        checkOutput("acc_cleared", outData, 32'hFFFFFFFB);
        applyStimulus(0, 0, 0, 1);
        checkOutput("acc_drained", outValid, 0);

        // Backpressure: four results fill the FIFO, fifth is held off.
        applyStimulus(1, 1, 19'd10, 0);
        applyStimulus(1, 1, 19'd20, 0);
        applyStimulus(1, 1, 19'd30, 0);
        checkOutput("bp_ready3", psumReady, 1);
        applyStimulus(1, 1, 19'd40, 0);
        checkOutput("bp_full_ready", psumReady, 0);
        applyStimulus(1, 1, 19'd50, 0);
        checkOutput("bp_hold_ready", psumReady, 0);
        checkOutput("bp_hold_data", outData, 32'd10);
        applyStimulus(1, 1, 19'd50, 1);
        checkOutput("bp_pop_data", outData, 32'd20);
        checkOutput("bp_pop_ready", psumReady, 1);
        applyStimulus(1, 1, 19'd50, 1);
        checkOutput("pp_data1", outData, 32'd30);
        checkOutput("pp_ready1", psumReady, 1);
        applyStimulus(1, 1, 19'd60, 1);
        checkOutput("pp_data2", outData, 32'd40);
        checkOutput("pp_ready2", psumReady, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("drain_50", outData, 32'd50);
        applyStimulus(0, 0, 0, 1);
        checkOutput("drain_60", outData, 32'd60);
        applyStimulus(0, 0, 0, 1);
        checkOutput("drain_empty", outValid, 0);

        // Overflow: a queued result, then MAX_PASSES non-last accepts.
        applyStimulus(1, 1, 19'd77, 0);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1, 0, 19'd1, 0);
        end
        checkOutput("ovf_before", passOvf, 0);
        checkOutput("ovf_before_ready", psumReady, 1);
        applyStimulus(1, 0, 19'd1, 0);
        checkOutput("ovf_set", passOvf, 1);
        checkOutput("ovf_ready", psumReady, 0);
        checkOutput("ovf_head", outData, 32'd77);
        applyStimulus(0, 0, 0, 1);
        checkOutput("ovf_drained", outValid, 0);
        checkOutput("ovf_sticky", passOvf, 1);

        // Reset mid-accumulation with a result still queued.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        applyStimulus(1, 1, 19'd9, 0);
        applyStimulus(1, 0, 19'd50, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", outValid, 0);
        checkOutput("mid_rst_data", outData, 0);
        checkOutput("mid_rst_ready", psumReady, 1);
        checkOutput("mid_rst_ovf", passOvf, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("post_rst_valid", outValid, 0);
        applyStimulus(1, 1, 19'd7, 0);
        checkOutput("post_rst_data", outData, 32'd7);
        applyStimulus(0, 0, 0, 1);

        // Saturation at both ends of the 32-bit range.
        applySat(1, 0, 32'h7FFFFFF0, 0);
        applySat(1, 1, 32'h0003FFFF, 0);
        checkOutput("sat_pos_valid", satOutValid, 1);
        checkOutput("sat_pos_data", satOutData, 32'h7FFFFFFF);
        applySat(0, 0, 0, 1);
        applySat(1, 0, 32'h80000010, 0);
        applySat(1, 1, 32'hFFFC0000, 0);
        checkOutput("sat_neg_data", satOutData, 32'h80000000);
        applySat(0, 0, 0, 1);
        applySat(1, 1, 32'd3, 0);
        checkOutput("sat_cleared", satOutData, 32'd3);
        applySat(0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
